// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one word-wide memory port between instruction fetch
// and data load/store. Sub-word loads are lane-extracted and extended; sub-word
// stores are performed as read-modify-write.
module mem_port_arbiter #(
  parameter int ADDRWIDTH = 32,
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [ADDRWIDTH-1:0] if_addr,
  output logic                 if_ack,
  output logic [DATAWIDTH-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [1:0]           d_size,
  input  logic                 d_unsigned,
  input  logic [ADDRWIDTH-1:0] d_addr,
  input  logic [DATAWIDTH-1:0] d_wdata,
  output logic                 d_ack,
  output logic [DATAWIDTH-1:0] d_rdata,
  output logic                 d_err,
  output logic [ADDRWIDTH-1:0] mem_address,
  output logic                 mem_read_write,
  output logic [DATAWIDTH-1:0] mem_data_in,
  input  logic [DATAWIDTH-1:0] mem_data_out
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_WR     = 3'd2;
  localparam logic [2:0] ST_RMW_RD = 3'd3;
  localparam logic [2:0] ST_RMW_WR = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  logic [2:0]           state_reg, state_next;
  logic [ADDRWIDTH-1:0] addr_reg;
  logic [1:0]           size_reg;
  logic                 we_reg;
  logic                 uns_reg;
  logic                 owner_d_reg;   // 1 = data port owns the access in flight
  logic                 last_d_reg;    // 1 = data was granted last, so fetch wins a tie
  logic [DATAWIDTH-1:0] wdata_reg;
  logic [DATAWIDTH-1:0] merge_reg;
  logic                 if_ack_reg, d_ack_reg, if_err_reg, d_err_reg;
  logic [DATAWIDTH-1:0] if_rdata_reg, d_rdata_reg;

  logic                 if_pending, d_pending, grant_if, grant_d;
  logic                 if_misaligned, d_bad;
  logic [ADDRWIDTH-1:0] aligned_addr;
  logic [7:0]           rd_byte [4];
  logic [DATAWIDTH-1:0] merged;
  logic [7:0]           sub_byte;
  logic [15:0]          sub_half;
  logic [DATAWIDTH-1:0] load_data;

  assign if_ack   = if_ack_reg;
  assign if_err   = if_err_reg;
  assign if_rdata = if_rdata_reg;
  assign d_ack    = d_ack_reg;
  assign d_err    = d_err_reg;
  assign d_rdata  = d_rdata_reg;

  // A requester still sitting in its ack cycle has already been served.
  assign if_pending = if_req & ~if_ack_reg;
  assign d_pending  = d_req & ~d_ack_reg;
  assign grant_if   = (state_reg == ST_IDLE) & if_pending & (~d_pending | last_d_reg);
  assign grant_d    = (state_reg == ST_IDLE) & d_pending & ~grant_if;

  assign if_misaligned = (if_addr[1:0] != 2'b00);
  assign d_bad = (d_size == 2'b11)
               | ((d_size == 2'b01) & d_addr[0])
               | ((d_size == 2'b10) & (d_addr[1:0] != 2'b00));

  assign aligned_addr = {addr_reg[ADDRWIDTH-1:2], 2'b00};

  // Per-lane read extraction and store merge for the RMW path.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       lane_hit;
      logic [7:0] lane_src;
      assign rd_byte[gi] = mem_data_out[8*gi +: 8];
      assign lane_hit = (size_reg == 2'b00) ? (addr_reg[1:0] == LANE)
                                            : (addr_reg[1] == LANE[1]);
      assign lane_src = ((size_reg == 2'b00) || !LANE[0]) ? wdata_reg[7:0]
                                                          : wdata_reg[15:8];
      assign merged[8*gi +: 8] = lane_hit ? lane_src : rd_byte[gi];
    end
  endgenerate

  // Load result: pick the addressed lane and sign/zero extend it.
  always_comb begin
    sub_byte = rd_byte[addr_reg[1:0]];
    sub_half = addr_reg[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    case (size_reg)
      2'b00:   load_data = {{24{~uns_reg & sub_byte[7]}}, sub_byte};
      2'b01:   load_data = {{16{~uns_reg & sub_half[15]}}, sub_half};
      default: load_data = mem_data_out;
    endcase
  end

  // Next-state decode; accepted requests are classified here.
  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE: begin
        if (grant_if) begin
          state_next = if_misaligned ? ST_ERR : ST_RD;
        end else if (grant_d) begin
          if (d_bad)                 state_next = ST_ERR;
          else if (!d_we)            state_next = ST_RD;
          else if (d_size == 2'b10)  state_next = ST_WR;
          else                       state_next = ST_RMW_RD;
        end
      end
      ST_RMW_RD: state_next = ST_RMW_WR;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Memory port drive; writes are masked by reset so a reset edge never writes.
  always_comb begin
    mem_address    = '0;
    mem_read_write = 1'b0;
    mem_data_in    = '0;
    case (state_reg)
      ST_RD, ST_RMW_RD: mem_address = aligned_addr;
      ST_WR: begin
        mem_address    = aligned_addr;
        mem_read_write = rst_n;
        mem_data_in    = wdata_reg;
      end
      ST_RMW_WR: begin
        mem_address    = aligned_addr;
        mem_read_write = rst_n;
        mem_data_in    = merge_reg;
      end
      default: ;
    endcase
  end

  // State, request latch, merge register and registered ack/err/rdata outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      size_reg     <= 2'b00;
      we_reg       <= 1'b0;
      uns_reg      <= 1'b0;
      owner_d_reg  <= 1'b0;
      last_d_reg   <= 1'b1;
      wdata_reg    <= '0;
      merge_reg    <= '0;
      if_ack_reg   <= 1'b0;
      d_ack_reg    <= 1'b0;
      if_err_reg   <= 1'b0;
      d_err_reg    <= 1'b0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      if_ack_reg <= 1'b0;
      d_ack_reg  <= 1'b0;
      if_err_reg <= 1'b0;
      d_err_reg  <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_if) begin
            addr_reg    <= if_addr;
            size_reg    <= 2'b10;
            we_reg      <= 1'b0;
            uns_reg     <= 1'b0;
            wdata_reg   <= '0;
            owner_d_reg <= 1'b0;
            last_d_reg  <= 1'b0;
          end else if (grant_d) begin
            addr_reg    <= d_addr;
            size_reg    <= d_size;
            we_reg      <= d_we;
            uns_reg     <= d_unsigned;
            wdata_reg   <= d_wdata;
            owner_d_reg <= 1'b1;
            last_d_reg  <= 1'b1;
          end
        end
        ST_RD: begin
          if (owner_d_reg) begin
            d_ack_reg   <= 1'b1;
            d_rdata_reg <= we_reg ? d_rdata_reg : load_data;
          end else begin
            if_ack_reg   <= 1'b1;
            if_rdata_reg <= load_data;
          end
        end
        ST_WR, ST_RMW_WR: d_ack_reg <= 1'b1;
        ST_RMW_RD: merge_reg <= merged;
        ST_ERR: begin
          if (owner_d_reg) begin
            d_ack_reg   <= 1'b1;
            d_err_reg   <= 1'b1;
            d_rdata_reg <= '0;
          end else begin
            if_ack_reg   <= 1'b1;
            if_err_reg   <= 1'b1;
            if_rdata_reg <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: word-array memory model, a reference memory with
// a behavioural access model, a per-cycle compare process and directed tests.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req, if_ack, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_unsigned, d_ack, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_read_write;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  // expectations for the access in flight on each port
  bit          if_exp_valid = 0, if_exp_err;
  logic [31:0] if_exp_rdata, if_hold = '0;
  bit          d_exp_valid = 0, d_exp_err, d_exp_store, d_exp_writes;
  logic [31:0] d_exp_rdata, d_hold = '0;

  mem_port_arbiter #(.ADDRWIDTH(32), .DATAWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // memory: combinational read, word write on the edge
  assign mem_data_out = mem[mem_address[9:2]];
  always @(posedge clk) if (mem_read_write) mem[mem_address[9:2]] <= mem_data_in;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Behavioural access model: alignment rule, lane shift/mask, extension.
  task automatic predict(input bit fetch, input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output bit err, output logic [31:0] rdata, output bit writes);
    int idx, off, nb;
    logic [31:0] v, mask;
    idx = int'(addr[9:2]);
    off = int'(addr[1:0]);
    nb  = fetch ? 4 : ((size == 2'd3) ? 0 : (1 << size));
    err = fetch ? (off != 0) : ((nb == 0) || (off % nb != 0));
    rdata  = '0;
    writes = 0;
    if (!err) begin
      if (fetch || !we) begin
        v = ref_mem[idx] >> (8 * off);
        if (nb == 1) begin
          v &= 32'hFF;
          if (!uns && v[7]) v |= 32'hFFFFFF00;
        end else if (nb == 2) begin
          v &= 32'hFFFF;
          if (!uns && v[15]) v |= 32'hFFFF0000;
        end
        rdata = v;
      end else begin
        mask = (nb == 4) ? 32'hFFFFFFFF : (((32'd1 << (8 * nb)) - 1) << (8 * off));
        ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wdata << (8 * off)) & mask);
        writes = 1;
      end
    end
  endtask

  // Per-cycle compare against the model expectations.
  always @(negedge clk) begin
    if (!rst_n) begin
      check1("rst_no_write", mem_read_write, 1'b0);
    end else begin
      check32("mem_addr_aligned", {30'b0, mem_address[1:0]}, 32'h0);
      if (mem_read_write) check1("write_allowed", d_exp_valid && d_exp_writes, 1'b1);
      if (if_ack) begin
        check1("if_ack_expected", if_exp_valid, 1'b1);
        check1("if_err", if_err, if_exp_err);
        check32("if_rdata", if_rdata, if_exp_rdata);
        if_hold = if_exp_rdata;
        if_exp_valid = 0;
      end else begin
        check1("if_err_idle", if_err, 1'b0);
        check32("if_rdata_hold", if_rdata, if_hold);
      end
      if (d_ack) begin
        check1("d_ack_expected", d_exp_valid, 1'b1);
        check1("d_err", d_err, d_exp_err);
        if (d_exp_store && !d_exp_err) begin
          check32("d_rdata_store_hold", d_rdata, d_hold);
        end else begin
          check32("d_rdata", d_rdata, d_exp_rdata);
          d_hold = d_exp_rdata;
        end
        d_exp_valid = 0;
      end else begin
        check1("d_err_idle", d_err, 1'b0);
        check32("d_rdata_hold", d_rdata, d_hold);
      end
    end
  end

  task automatic start_if(input logic [31:0] a);
    bit w;
    if_addr = a;
    if_req  = 1;
    predict(1, 0, 2'b10, 0, a, 32'h0, if_exp_err, if_exp_rdata, w);
    if_exp_valid = 1;
  endtask

  task automatic start_d(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
    d_we = we; d_size = size; d_unsigned = uns; d_addr = a; d_wdata = wd;
    d_req = 1;
    predict(0, we, size, uns, a, wd, d_exp_err, d_exp_rdata, d_exp_writes);
    d_exp_store = we;
    d_exp_valid = 1;
  endtask

  task automatic wait_if(output int ack_cyc);
    bit got = 0;
    ack_cyc = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      if (if_ack) begin got = 1; ack_cyc = cyc; end
    end
    if_req = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL if_timeout: no if_ack within 20 cycles, required one");
      if_exp_valid = 0;
    end
  endtask

  task automatic wait_d(output int ack_cyc);
    bit got = 0;
    ack_cyc = -1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      if (d_ack) begin got = 1; ack_cyc = cyc; end
    end
    d_req = 0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL d_timeout: no d_ack within 20 cycles, required one");
      d_exp_valid = 0;
    end
  endtask

  task automatic do_if(input logic [31:0] a, input int exp_lat, input string name,
                       output logic [31:0] rd, output logic er);
    int s, ac;
    @(posedge clk); #1;
    s = cyc;
    start_if(a);
    wait_if(ac);
    rd = if_rdata;
    er = if_err;
    check32({name, "_lat"}, 32'(ac - s), 32'(exp_lat));
    $display("txn %s: fetch addr=%08h rdata=%08h err=%0b lat=%0d", name, a, rd, er, ac - s);
  endtask

  task automatic do_d(input bit we, input logic [1:0] size, input bit uns, input logic [31:0] a,
                      input logic [31:0] wd, input int exp_lat, input string name,
                      output logic [31:0] rd, output logic er);
    int s, ac;
    @(posedge clk); #1;
    s = cyc;
    start_d(we, size, uns, a, wd);
    wait_d(ac);
    rd = d_rdata;
    er = d_err;
    check32({name, "_lat"}, 32'(ac - s), 32'(exp_lat));
    $display("txn %s: we=%0b size=%0d uns=%0b addr=%08h wdata=%08h rdata=%08h err=%0b lat=%0d",
             name, we, size, uns, a, wd, rd, er, ac - s);
  endtask

  // Both ports request in the same cycle; check which one is served first.
  task automatic do_tie(input logic [31:0] fa, input logic [31:0] da,
                        input int exp_if_lat, input int exp_d_lat, input string name);
    int s, ic, dc;
    @(posedge clk); #1;
    s = cyc;
    start_if(fa);
    start_d(0, 2'b10, 0, da, 32'h0);
    fork
      wait_if(ic);
      wait_d(dc);
    join
    check32({name, "_if_lat"}, 32'(ic - s), 32'(exp_if_lat));
    check32({name, "_d_lat"}, 32'(dc - s), 32'(exp_d_lat));
    $display("txn %s: fetch %08h acked +%0d, load %08h acked +%0d", name, fa, ic - s, da, dc - s);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 0;
    if_req = 0; d_req = 0;
    if_exp_valid = 0; d_exp_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    if_hold = '0; d_hold = '0;
  endtask

  initial begin
    logic [31:0] rd, saved;
    logic er;
    rst_n = 0;
    if_req = 0; if_addr = '0;
    d_req = 0; d_we = 0; d_size = 2'b00; d_unsigned = 0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i] <= 32'h1000_0000 + 32'(i) * 32'h0101;
      ref_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    end
    mem[0] <= 32'h00940333;
    ref_mem[0] = 32'h00940333;

    repeat (3) @(posedge clk);
    #1;
    check1("rst_if_ack", if_ack, 1'b0);
    check1("rst_d_ack", d_ack, 1'b0);
    check1("rst_if_err", if_err, 1'b0);
    check1("rst_d_err", d_err, 1'b0);
    check32("rst_if_rdata", if_rdata, 32'h0);
    check32("rst_d_rdata", d_rdata, 32'h0);
    check32("rst_mem_address", mem_address, 32'h0);
    rst_n = 1;

    do_if(32'h01000000, 2, "fetch_w0", rd, er);
    check32("fetch_w0_data", rd, 32'h00940333);
    check1("fetch_w0_err", er, 1'b0);

    do_d(0, 2'b00, 0, 32'h01000002, 32'h0, 2, "lb", rd, er);
    check32("lb_data", rd, 32'hFFFFFF94);
    do_d(0, 2'b00, 1, 32'h01000002, 32'h0, 2, "lbu", rd, er);
    check32("lbu_data", rd, 32'h00000094);
    do_d(0, 2'b01, 0, 32'h01000002, 32'h0, 2, "lh", rd, er);
    check32("lh_data", rd, 32'h00000094);

    do_d(1, 2'b00, 0, 32'h01000001, 32'h000000AB, 3, "sb", rd, er);
    check32("sb_rdata_unchanged", rd, 32'h00000094);
    do_d(0, 2'b10, 0, 32'h01000000, 32'h0, 2, "lw_after_sb", rd, er);
    check32("lw_after_sb_data", rd, 32'h0094AB33);
    do_d(1, 2'b01, 0, 32'h01000002, 32'h0000BEEF, 3, "sh", rd, er);
    do_d(0, 2'b10, 0, 32'h01000000, 32'h0, 2, "lw_after_sh", rd, er);
    check32("lw_after_sh_data", rd, 32'hBEEFAB33);
    do_d(0, 2'b01, 0, 32'h01000002, 32'h0, 2, "lh_beef", rd, er);
    check32("lh_beef_data", rd, 32'hFFFFBEEF);

    do_d(1, 2'b10, 0, 32'h01000010, 32'h12345678, 2, "sw", rd, er);
    do_d(0, 2'b01, 1, 32'h01000012, 32'h0, 2, "lhu_hi", rd, er);
    check32("lhu_hi_data", rd, 32'h00001234);
    do_d(0, 2'b00, 0, 32'h01000013, 32'h0, 2, "lb_lane3", rd, er);
    check32("lb_lane3_data", rd, 32'h00000012);

    // arbitration: fetch first from reset, alternating afterwards
    do_reset();
    do_tie(32'h01000000, 32'h01000010, 2, 4, "tie1");
    do_tie(32'h01000000, 32'h01000010, 2, 4, "tie2");
    do_if(32'h01000004, 2, "fetch_w1", rd, er);
    do_tie(32'h01000008, 32'h01000010, 4, 2, "tie3");

    // error accesses
    do_d(0, 2'b10, 0, 32'h01000002, 32'h0, 2, "lw_misaligned", rd, er);
    check1("lw_misaligned_err", er, 1'b1);
    check32("lw_misaligned_rdata", rd, 32'h0);
    do_d(0, 2'b11, 0, 32'h01000000, 32'h0, 2, "size11", rd, er);
    check1("size11_err", er, 1'b1);
    do_d(0, 2'b01, 0, 32'h01000001, 32'h0, 2, "lh_odd", rd, er);
    check1("lh_odd_err", er, 1'b1);
    do_d(1, 2'b10, 0, 32'h01000001, 32'hDEADBEEF, 2, "sw_misaligned", rd, er);
    check1("sw_misaligned_err", er, 1'b1);
    do_d(1, 2'b11, 0, 32'h01000004, 32'hDEADBEEF, 2, "st_size11", rd, er);
    check1("st_size11_err", er, 1'b1);
    do_if(32'h01000002, 2, "fetch_misaligned", rd, er);
    check1("fetch_misaligned_err", er, 1'b1);
    check32("fetch_misaligned_rdata", rd, 32'h0);
    check32("mem_w0_after_errors", mem[0], 32'hBEEFAB33);

    // reset asserted while the RMW write is being presented
    @(posedge clk); #1;
    saved = ref_mem[0];
    start_d(1, 2'b00, 0, 32'h01000000, 32'h0000005A);
    @(posedge clk); @(posedge clk); #1;
    check1("rmw_wr_presented", mem_read_write, 1'b1);
    rst_n = 0;
    d_exp_valid = 0;
    ref_mem[0] = saved;
    #1;
    check1("rmw_wr_masked", mem_read_write, 1'b0);
    @(posedge clk); #1;
    d_req = 0;
    check32("rmw_reset_mem_unchanged", mem[0], saved);
    check1("rmw_reset_d_ack", d_ack, 1'b0);
    check1("rmw_reset_if_ack", if_ack, 1'b0);
    @(posedge clk); #1;
    rst_n = 1;
    if_hold = '0; d_hold = '0;
    @(posedge clk); #1;
    check1("post_reset_d_ack", d_ack, 1'b0);
    check32("post_reset_idle_addr", mem_address, 32'h0);
    check1("post_reset_idle_rw", mem_read_write, 1'b0);

    for (int i = 0; i < 8; i++) check32($sformatf("mem_final_%0d", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
